seq_shift_multiplier: RTL and testbench

SEQ_SHIFT_MULTIPLIER -- requirements
Module: seq_shift_multiplier

---
 rtl/seq_shift_multiplier.sv | 115 +++++++++++
 tb/tb_seq_shift_multiplier.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_multiplier.sv
// Sequential shift-and-add multiplier, signed or unsigned N x N -> 2N.
// Sign-magnitude datapath: multiply the magnitudes, negate the product at the end.
module seq_shift_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N:0]     a;
  logic [N-1:0]   q;
  logic [N-1:0]   m;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           fin_d;

  logic           accept;
  logic           x_neg;
  logic           y_neg;
  logic [N-1:0]   x_mag;
  logic [N-1:0]   y_mag;
  logic [N:0]     sum;
  logic [2*N:0]   shifted;
  logic [2*N-1:0] mag;
  logic [2*N-1:0] res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == CNT_ONE) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && start;

  assign x_neg = signed_mode & x[N-1];
  assign y_neg = signed_mode & y[N-1];
  assign x_mag = x_neg ? -x : x;
  assign y_mag = y_neg ? -y : y;

  // (N+1)-bit sum of two N-bit magnitudes cannot overflow
  assign sum     = q[0] ? (a + {1'b0, m}) : a;
  assign shifted = {1'b0, sum, q[N-1:1]};

  assign mag = {a[N-1:0], q};
  assign res = neg ? -mag : mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      q   <= '0;
      m   <= '0;
      cnt <= '0;
      neg <= 1'b0;
    end else if (accept) begin
      a   <= '0;
      q   <= y_mag;
      m   <= x_mag;
      cnt <= CNT_INIT;
      neg <= signed_mode & (x[N-1] ^ y[N-1]);
    end else if (state == RUN) begin
      a   <= shifted[2*N:N];
      q   <= shifted[N-1:0];
      cnt <= cnt - CNT_ONE;
    end
  end

  // Outputs are registered one edge behind the FSM; p reads A/Q
  // before a back-to-back accept on the same edge overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_d <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      fin_d <= (state == FIN);
      busy  <= (state != IDLE);
      done  <= fin_d;
      if (fin_d) p <= res;
    end
  end

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Directed and randomized checks of seq_shift_multiplier at N=4 and N=8.
// Expected products are hand-computed or from native integer multiply.
module tb_seq_shift_multiplier;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start4, sm4;
  logic [3:0] x4, y4;
  logic       busy4, done4;
  logic [7:0] p4;

  logic        start8, sm8;
  logic [7:0]  x8, y8;
  logic        busy8, done8;
  logic [15:0] p8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_shift_multiplier #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
    .x(x4), .y(y4), .busy(busy4), .done(done4), .p(p4)
  );

  seq_shift_multiplier #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .p(p8)
  );

  task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                     output logic [7:0] prod, output int lat, output int bc);
    sm4 = sm; x4 = a; y4 = b; start4 = 1'b1;
    lat = -1; bc = 0; prod = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) start4 = 1'b0;
      if (busy4) bc++;
      if (done4) begin
        lat = j; prod = p4;
        break;
      end
    end
  endtask

  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] prod, output int lat, output int bc);
    sm8 = sm; x8 = a; y8 = b; start8 = 1'b1;
    lat = -1; bc = 0; prod = '0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) start8 = 1'b0;
      if (busy8) bc++;
      if (done8) begin
        lat = j; prod = p8;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start4 = 0; sm4 = 0; x4 = 0; y4 = 0;
    start8 = 0; sm8 = 0; x8 = 0; y8 = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy4, done4, p4} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_n4: got busy=%b done=%b p=%h want 0/0/00", busy4, done4, p4);
    end
    n_cmp++;
    if ({busy8, done8, p8} !== 18'b0) begin
      n_bad++;
      $display("FAIL reset_n8: got busy=%b done=%b p=%h want 0/0/0000", busy8, done8, p8);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy8 !== 1'b0 || busy4 !== 1'b0) begin
      n_bad++;
      $display("FAIL release_idle: got busy4=%b busy8=%b want 0/0", busy4, busy8);
    end
  endtask

  task automatic test_unsigned_n4;
    logic [7:0] pr;
    int lat, bc;
    op4(1'b0, 4'd13, 4'd11, pr, lat, bc);
    n_cmp++;
    if (lat !== 6) begin
      n_bad++;
      $display("FAIL n4_latency: got %0d want 6", lat);
    end
    n_cmp++;
    if (pr !== 8'd143) begin
      n_bad++;
      $display("FAIL n4_13x11: got %0d want 143", pr);
    end
    n_cmp++;
    if (bc !== 5) begin
      n_bad++;
      $display("FAIL n4_busy_cycles: got %0d want 5", bc);
    end
    @(negedge clk);
    n_cmp++;
    if (done4 !== 1'b0 || p4 !== 8'd143) begin
      n_bad++;
      $display("FAIL n4_done_pulse: got done=%b p=%0d want 0/143", done4, p4);
    end
  endtask

  task automatic test_signed_n4;
    logic [7:0] pr;
    int lat, bc;
    op4(1'b1, 4'b1000, 4'b1000, pr, lat, bc);
    n_cmp++;
    if (pr !== 8'd64 || lat !== 6) begin
      n_bad++;
      $display("FAIL n4_m8xm8: got p=%h lat=%0d want 40 lat 6", pr, lat);
    end
    op4(1'b1, 4'b1000, 4'd7, pr, lat, bc);
    n_cmp++;
    if (pr !== 8'hC8 || lat !== 6) begin
      n_bad++;
      $display("FAIL n4_m8x7: got p=%h lat=%0d want c8 lat 6", pr, lat);
    end
  endtask

  task automatic test_n8_edges;
    logic [15:0] pr;
    int lat, bc;
    op8(1'b1, 8'h80, 8'h01, pr, lat, bc);
    n_cmp++;
    if (pr !== 16'hFF80) begin
      n_bad++;
      $display("FAIL n8_signed_80x01: got %h want ff80", pr);
    end
    n_cmp++;
    if (lat !== 10 || bc !== 9) begin
      n_bad++;
      $display("FAIL n8_timing: got lat=%0d busy=%0d want 10/9", lat, bc);
    end
    op8(1'b0, 8'h80, 8'h01, pr, lat, bc);
    n_cmp++;
    if (pr !== 16'h0080) begin
      n_bad++;
      $display("FAIL n8_unsigned_80x01: got %h want 0080", pr);
    end
    op8(1'b1, 8'h00, 8'hFF, pr, lat, bc);
    n_cmp++;
    if (pr !== 16'h0000 || lat !== 10) begin
      n_bad++;
      $display("FAIL n8_zero_neg: got p=%h lat=%0d want 0000 lat 10", pr, lat);
    end
  endtask

  task automatic test_back_to_back;
    int dj[$];
    logic [15:0] dp[$];
    sm8 = 1'b0; x8 = 8'd3; y8 = 8'd5; start8 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 3)  begin sm8 = 1'b0; x8 = 8'd7;  y8 = 8'd9;   end
      if (j == 13) begin sm8 = 1'b1; x8 = 8'hFE; y8 = 8'd100; end
      if (j == 23) begin sm8 = 1'b0; x8 = 8'hFF; y8 = 8'hFF;  end
      if (j == 25) start8 = 1'b0;
      if (done8) begin
        dj.push_back(j);
        dp.push_back(p8);
      end
    end
    n_cmp++;
    if (dj.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_pulses: got %0d want 3", dj.size());
    end else begin
      n_cmp++;
      if (dj[0] != 10 || dj[1] != 20 || dj[2] != 30) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d,%0d,%0d want 10,20,30", dj[0], dj[1], dj[2]);
      end
      n_cmp++;
      if (dp[0] !== 16'h000F || dp[1] !== 16'h003F || dp[2] !== 16'hFF38) begin
        n_bad++;
        $display("FAIL b2b_products: got %h,%h,%h want 000f,003f,ff38", dp[0], dp[1], dp[2]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] pr;
    int lat, bc;
    sm8 = 1'b0; x8 = 8'd9; y8 = 8'd7; start8 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j == 0) start8 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy8, done8, p8} !== 18'b0) begin
      n_bad++;
      $display("FAIL midrun_reset: got busy=%b done=%b p=%h want 0/0/0000", busy8, done8, p8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || p8 !== 16'h0) begin
      n_bad++;
      $display("FAIL midrun_abort: got busy=%b done=%b p=%h want 0/0/0000", busy8, done8, p8);
    end
    op8(1'b1, 8'hF4, 8'hF4, pr, lat, bc);
    n_cmp++;
    if (pr !== 16'h0090 || lat !== 10) begin
      n_bad++;
      $display("FAIL after_reset: got p=%h lat=%0d want 0090 lat 10", pr, lat);
    end
  endtask

  function automatic logic [3:0] pick4();
    case ($urandom_range(0, 4))
      0: return 4'h0;
      1: return 4'hF;
      2: return 4'h8;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 4))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random;
    logic [7:0]  pr4, e4;
    logic [15:0] pr8, e8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic        sm;
    int lat, bc, r;
    for (int i = 0; i < 600; i++) begin
      sm = 1'($urandom);
      a4 = pick4(); b4 = pick4();
      r = sm ? int'($signed(a4)) * int'($signed(b4)) : int'(a4) * int'(b4);
      e4 = r[7:0];
      op4(sm, a4, b4, pr4, lat, bc);
      n_cmp++;
      if (pr4 !== e4 || lat != 6) begin
        n_bad++;
        $display("FAIL rand_n4 sm=%b %h*%h: got %h lat=%0d want %h lat 6", sm, a4, b4, pr4, lat, e4);
      end
      sm = 1'($urandom);
      a8 = pick8(); b8 = pick8();
      r = sm ? int'($signed(a8)) * int'($signed(b8)) : int'(a8) * int'(b8);
      e8 = r[15:0];
      op8(sm, a8, b8, pr8, lat, bc);
      n_cmp++;
      if (pr8 !== e8 || lat != 10) begin
        n_bad++;
        $display("FAIL rand_n8 sm=%b %h*%h: got %h lat=%0d want %h lat 10", sm, a8, b8, pr8, lat, e8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_n4();
    test_signed_n4();
    test_n8_edges();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
